// File: rtl/arbiter_x4_pkg.sv
// Shared constants and state encoding for the 4-way round-robin arbiter.
package arbiter_x4_pkg;

  localparam int ARB_N = 4;
  localparam logic [1:0] ARB_PTR_RST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/arbiter_x4_rr_pick.sv
// Combinational round-robin picker: the first requester after ptr (wrapping) wins.
module rr_pick_x4
  import arbiter_x4_pkg::*;
(
  input  logic [ARB_N-1:0] req,
  input  logic [1:0]       ptr,
  output logic [1:0]       id,
  output logic             any
);

  logic [1:0]         sh;
  logic [2*ARB_N-1:0] dbl;
  logic [ARB_N-1:0]   rot;
  logic [1:0]         off;

  // Rotate so the highest-priority requester lands in bit 0, then pick the lowest set bit.
  assign sh  = ptr + 2'd1;
  assign dbl = {req, req} >> sh;
  assign rot = dbl[ARB_N-1:0];

  always_comb begin
    off = 2'd0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (rot[i]) off = 2'(i);
    end
  end

  assign id  = off + sh;
  assign any = |req;

endmodule

// File: rtl/arbiter_x4.sv
// Round-robin arbiter for 4 requesters with a forced turnaround cycle between grants.
// Optional hold limit enabled by defining ARB_TIMEOUT_EN.
module arbiter_x4
  import arbiter_x4_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ARB_N-1:0] req,
  output logic [ARB_N-1:0] grant,
  output logic [1:0]       gnt_id,
  output logic             busy,
  output logic             timeout,
  output state_t           dbg_state
);

  if (MAX_HOLD < 1 || (64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_cfg
    $error("arbiter_x4: need MAX_HOLD >= 1 and 2**CNT_W > MAX_HOLD");
  end

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [ARB_N-1:0] grant_q, grant_d;
  logic [1:0]       id_q, id_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       pick_id;
  logic             pick_any;
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  rr_pick_x4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .id  (pick_id),
    .any (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    id_d      = id_q;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_GRANT: begin
        // A normal release outranks the hold limit on the same edge.
        if (!req[id_q]) begin
          state_d = ST_GAP;
          grant_d = '0;
          id_d    = 2'd0;
          ptr_d   = id_q;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(MAX_HOLD)) begin
          state_d   = ST_GAP;
          grant_d   = '0;
          id_d      = 2'd0;
          ptr_d     = id_q;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        // IDLE and GAP both arbitrate among whatever is requesting right now.
        if (pick_any) begin
          state_d = ST_GRANT;
          grant_d = ARB_N'(1) << pick_id;
          id_d    = pick_id;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = CNT_W'(1);
`endif
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
          id_d    = 2'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= ARB_PTR_RST;
      grant_q   <= '0;
      id_q      <= 2'd0;
      timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      timeout_q <= timeout_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign gnt_id    = id_q;
  assign busy      = |grant_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_arbiter_x4.sv
// Bench for arbiter_x4: directed scenarios then random traffic, checked every cycle
// against an owner/pointer model of the round-robin rules.
module tb_arbiter_x4;
  import arbiter_x4_pkg::*;

`ifdef ARB_TIMEOUT_EN
  localparam int MAXH = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int MAXH = 16;
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;
  state_t     dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Model: owner = -1 when the resource is free.
  int m_owner = -1;
  int m_ptr   = 3;
  int m_hold  = 0;
  bit m_gap   = 1'b0;
  bit m_tmo   = 1'b0;

  arbiter_x4 #(.MAX_HOLD(MAXH), .CNT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .grant     (grant),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] r, input logic rst);
    if (rst) begin
      m_owner = -1; m_ptr = 3; m_hold = 0; m_gap = 0; m_tmo = 0;
      return;
    end
    m_tmo = 0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_ptr = m_owner; m_owner = -1; m_gap = 1;
      end else if (TO_EN && m_hold == MAXH) begin
        m_ptr = m_owner; m_owner = -1; m_gap = 1; m_tmo = 1;
      end else begin
        m_hold++;
      end
    end else begin
      m_gap = 0;
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (r[c] && m_owner < 0) begin
          m_owner = c; m_hold = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] eg;
    logic [3:0] ei;
    logic [3:0] es;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    ei = (m_owner >= 0) ? 4'(m_owner) : 4'd0;
    es = (m_owner >= 0) ? 4'd1 : (m_gap ? 4'd2 : 4'd0);
    check("grant", grant, eg);
    check("gnt_id", {2'b00, gnt_id}, ei);
    check("busy", {3'b000, busy}, {3'b000, (m_owner >= 0)});
    check("timeout", {3'b000, timeout}, {3'b000, m_tmo});
    check("state", {2'b00, dbg_state}, es);
    check("onehot", {3'b000, ($countones(grant) <= 1)}, 4'd1);
  endtask

  // One clock: drive at negedge, model the posedge, compare shortly after it.
  task automatic step(input logic [3:0] r, input logic rst = 1'b0);
    @(negedge clk);
    req = r;
    reset = rst;
    @(posedge clk);
    model_edge(r, rst);
    #1;
    compare_all();
  endtask

  task automatic step_exp(input string tag, input logic [3:0] r, input logic [3:0] exp_grant);
    step(r);
    check(tag, grant, exp_grant);
  endtask

  initial begin
    logic [3:0] rr;
    // 1: reset, all request, release in turn -> 0,1,2,3
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("reset_grant", grant, 4'b0000);
    check("reset_timeout", {3'b000, timeout}, 4'd0);
    step_exp("t1_first", 4'b1111, 4'b0001);
    step(4'b1111);
    step_exp("t1_gap0", 4'b1110, 4'b0000);
    step_exp("t1_g1", 4'b1110, 4'b0010);
    step_exp("t1_gap1", 4'b1100, 4'b0000);
    step_exp("t1_g2", 4'b1100, 4'b0100);
    step_exp("t1_gap2", 4'b1000, 4'b0000);
    step_exp("t1_g3", 4'b1000, 4'b1000);
    step(4'b0000);
    step(4'b0000);
    // 2: re-requesting releaser goes last
    step_exp("t2_g0", 4'b0001, 4'b0001);
    step(4'b0000);
    step_exp("t2_g2", 4'b0101, 4'b0100);
    step(4'b0000);
    // 3: release and new request on the same edge
    step_exp("t3_g1", 4'b0010, 4'b0010);
    step_exp("t3_gap", 4'b1000, 4'b0000);
    step_exp("t3_g3", 4'b1000, 4'b1000);
    step(4'b0000);
    step(4'b0000);
    // 4: reset mid-grant
    step_exp("t4_g2", 4'b0100, 4'b0100);
    step(4'b0100, 1'b1);
    check("t4_rst_grant", grant, 4'b0000);
    check("t4_rst_busy", {3'b000, busy}, 4'd0);
    step_exp("t4_after", 4'b1111, 4'b0001);
    // 5/6: one requester held long; revoked after MAXH cycles only with the hold limit
    step(4'b0000);
    step(4'b0000);
    for (int i = 0; i < 100; i++) step(4'b0100);
`ifndef ARB_TIMEOUT_EN
    check("t6_held", grant, 4'b0100);
`endif
    step(4'b0000);
    step(4'b0000);
    // Random traffic: sticky requests that occasionally toggle, rare resets.
    rr = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) rr[b] = ~rr[b];
      end
      step(rr, ($urandom_range(0, 79) == 0));
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
